// File: rtl/afe_pkg.sv
// Shared definitions for the AFE SPI master: parameter defaults and FSM states.
package afe_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 4;
    localparam int unsigned CS_GAP_DEFAULT  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SCLK_LO = 3'd2,
        SCLK_HI = 3'd3,
        HOLD    = 3'd4,
        GAP     = 3'd5
    } afe_state_e;

endpackage

// File: rtl/afe_spi_tick.sv
// SCLK phase timer: 8-bit reloadable down-counter with a phase-end strobe.
module afe_spi_tick (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       tick
);

    logic [7:0] cnt_q, cnt_d;

    // Reload on every phase change; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/afe_spi_master.sv
// SPI mode-0 master for the AFE slave: one byte out (GPIO), one byte in (TOT).
module afe_spi_master
    import afe_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned CS_GAP  = CS_GAP_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_B,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RX_DATA,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       CS_B
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

    afe_state_e state_q, state_d;
    logic       cs_b_q, cs_b_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [2:0] bit_q, bit_d;
    logic       load;
    logic [7:0] load_val;
    logic       tick;

    afe_spi_tick u_tick (
        .clk      (CLK),
        .rst_n    (RST_B),
        .load     (load),
        .load_val (load_val),
        .tick     (tick)
    );

    // Next-state and output logic; every phase change reloads the timer.
    always_comb begin
        state_d  = state_q;
        cs_b_d   = cs_b_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rx_d     = rx_q;
        tx_sh_d  = tx_sh_q;
        rx_sh_d  = rx_sh_q;
        bit_d    = bit_q;
        load     = 1'b0;
        load_val = DIV_RELOAD;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = SETUP;
                    load    = 1'b1;
                    cs_b_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = TX_DATA[7];
                    tx_sh_d = {TX_DATA[6:0], 1'b0};
                    rx_sh_d = '0;
                    bit_d   = '0;
                end
            end
            SETUP, SCLK_LO: begin
                if (tick) begin
                    state_d = SCLK_HI;
                    load    = 1'b1;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], MISO};
                end
            end
            SCLK_HI: begin
                if (tick) begin
                    load   = 1'b1;
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SCLK_LO;
                        bit_d   = bit_q + 3'd1;
                        mosi_d  = tx_sh_q[7];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d  = GAP;
                    load     = 1'b1;
                    load_val = GAP_RELOAD;
                    cs_b_d   = 1'b1;
                    done_d   = 1'b1;
                    rx_d     = rx_sh_q;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transfer with CS_B high.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q <= IDLE;
            cs_b_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= '0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_b_q  <= cs_b_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            bit_q   <= bit_d;
        end
    end

    assign CS_B    = cs_b_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RX_DATA = rx_q;

endmodule

// File: tb/tb_afe_spi_master.sv
// Testbench for afe_spi_master: loopback, slave model and MISO-pattern scenarios.
module tb_afe_spi_master;

    localparam int NA = 4;
    localparam int GA = 4;
    localparam int NB = 2;
    localparam int GB = 2;
    localparam int PA = 17 * NA + GA + 1;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: default timing, loopback or pattern-driven MISO
    logic       a_start, a_busy, a_done, a_sclk, a_mosi, a_miso, a_cs_b;
    logic [7:0] a_tx, a_rx;

    afe_spi_master #(.CLK_DIV(NA), .CS_GAP(GA)) dut_a (
        .CLK(clk), .RST_B(rst_b), .START(a_start), .TX_DATA(a_tx),
        .BUSY(a_busy), .DONE(a_done), .RX_DATA(a_rx), .SCLK(a_sclk),
        .MOSI(a_mosi), .MISO(a_miso), .CS_B(a_cs_b)
    );

    // DUT B: fast timing, talking to a behavioural AFE slave
    logic       b_start, b_busy, b_done, b_sclk, b_mosi, b_miso, b_cs_b;
    logic [7:0] b_tx, b_rx;

    afe_spi_master #(.CLK_DIV(NB), .CS_GAP(GB)) dut_b (
        .CLK(clk), .RST_B(rst_b), .START(b_start), .TX_DATA(b_tx),
        .BUSY(b_busy), .DONE(b_done), .RX_DATA(b_rx), .SCLK(b_sclk),
        .MOSI(b_mosi), .MISO(b_miso), .CS_B(b_cs_b)
    );

    // SCLK edge counters on A (all edges, and edges seen while deselected)
    int a_rises = 0;
    int a_bad   = 0;
    always @(posedge a_sclk) begin
        a_rises <= a_rises + 1;
        if (a_cs_b) a_bad <= a_bad + 1;
    end

    // MISO source for A: loopback, or a byte held stable in low phases with noise in high phases
    int         miso_mode = 0;
    int         pat_base  = 0;
    logic [7:0] pat_byte  = 8'h5A;
    logic       pat_miso  = 1'b0;
    int         pat_k;
    always_comb pat_k = a_rises - pat_base;
    always @(negedge clk) begin
        if (a_sclk) pat_miso <= 1'($urandom);
        else if (pat_k >= 0 && pat_k < 8) pat_miso <= pat_byte[3'(7 - pat_k)];
        else pat_miso <= 1'b0;
    end
    always_comb a_miso = (miso_mode == 1) ? pat_miso : a_mosi;

    // Behavioural AFE slave on B: returns TOT, captures GPIO, latches GPIO on CS_B rise
    logic [7:0] s_tot = 8'h00;
    logic [7:0] s_sh = 8'h00, s_gpio_sh = 8'h00, s_gpio = 8'h00;
    int         b_rises = 0;
    always @(negedge b_cs_b) begin
        s_sh      <= s_tot;
        s_gpio_sh <= '0;
    end
    always @(posedge b_sclk) begin
        s_gpio_sh <= {s_gpio_sh[6:0], b_mosi};
        b_rises   <= b_rises + 1;
    end
    always @(negedge b_sclk) if (!b_cs_b) s_sh <= {s_sh[6:0], 1'b0};
    always @(posedge b_cs_b) s_gpio <= s_gpio_sh;
    always_comb b_miso = s_sh[7];

    // Results of the last run_a call
    int         r_done, r_busylo, r_ndone, r_rises, r_bad;
    logic [7:0] r_rx;
    logic       r_setup_ok, r_hold_ok;

    // One transfer on A starting at the next negedge; cycle c is observed at the c-th negedge after the accept edge.
    task automatic run_a(input logic [7:0] tx, input logic [7:0] tx_late, input int pulse_at, input int limit);
        int r0, b0;
        @(negedge clk);
        a_tx = tx; a_start = 1'b1;
        r0 = a_rises; b0 = a_bad;
        r_done = -1; r_busylo = -1; r_ndone = 0; r_rx = 8'hxx;
        r_setup_ok = 1'b0; r_hold_ok = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_start = 1'b0;
                a_tx = tx_late;
                r_setup_ok = (a_cs_b === 1'b0) && (a_sclk === 1'b0) && (a_mosi === tx[7]) && (a_busy === 1'b1);
            end
            if (c == pulse_at) a_start = 1'b1;
            if (c == pulse_at + 1) a_start = 1'b0;
            if (c == 16 * NA + 1) r_hold_ok = (a_cs_b === 1'b0) && (a_sclk === 1'b0) && (a_busy === 1'b1);
            if (a_done === 1'b1) begin
                r_ndone++;
                if (r_done < 0) begin r_done = c; r_rx = a_rx; end
            end
            if (a_busy === 1'b0 && r_busylo < 0) r_busylo = c;
        end
        r_rises = a_rises - r0;
        r_bad   = a_bad - b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; a_start = 1'b0; b_start = 1'b0; a_tx = '0; b_tx = '0; miso_mode = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_cs_b, a_sclk, a_mosi, a_busy, a_done} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl_a got %b want 10000", {a_cs_b, a_sclk, a_mosi, a_busy, a_done});
        end
        checks++;
        if (a_rx !== 8'h00) begin errors++; $display("FAIL reset_rx_a got %h want 00", a_rx); end
        checks++;
        if ({b_cs_b, b_sclk, b_mosi, b_busy, b_done, b_rx} !== {5'b10000, 8'h00}) begin
            errors++; $display("FAIL reset_b got %b %h want 10000 00", {b_cs_b, b_sclk, b_mosi, b_busy, b_done}, b_rx);
        end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_loopback();
        logic [7:0] tx;
        miso_mode = 0;
        for (int i = 0; i < 4; i++) begin
            tx = (i == 0) ? 8'hA5 : 8'($urandom);
            run_a(tx, ~tx, -1, PA);
            checks++; if (r_rx !== tx) begin errors++; $display("FAIL loop_rx[%0d] got %h want %h", i, r_rx, tx); end
            checks++; if (r_done != 17 * NA + 1) begin errors++; $display("FAIL loop_done_cycle[%0d] got %0d want %0d", i, r_done, 17 * NA + 1); end
            checks++; if (r_busylo != PA) begin errors++; $display("FAIL loop_busy_low[%0d] got %0d want %0d", i, r_busylo, PA); end
            checks++; if (r_rises != 8) begin errors++; $display("FAIL loop_sclk_rises[%0d] got %0d want 8", i, r_rises); end
            checks++; if (r_bad != 0) begin errors++; $display("FAIL loop_sclk_while_cs_high[%0d] got %0d want 0", i, r_bad); end
            checks++; if (r_setup_ok !== 1'b1) begin errors++; $display("FAIL loop_setup[%0d] got %b want 1", i, r_setup_ok); end
            checks++; if (r_hold_ok !== 1'b1) begin errors++; $display("FAIL loop_hold[%0d] got %b want 1", i, r_hold_ok); end
            checks++; if (r_ndone != 1) begin errors++; $display("FAIL loop_done_count[%0d] got %0d want 1", i, r_ndone); end
        end
    endtask

    task automatic test_slave();
        logic [7:0] tx, tot, rxd;
        int dc, nd, r0;
        for (int i = 0; i < 4; i++) begin
            tx  = (i == 0) ? 8'h81 : 8'($urandom);
            tot = (i == 0) ? 8'h3C : 8'($urandom);
            @(negedge clk);
            s_tot = tot; b_tx = tx; b_start = 1'b1;
            r0 = b_rises; dc = -1; nd = 0; rxd = 8'hxx;
            for (int c = 1; c <= 17 * NB + GB + 1; c++) begin
                @(negedge clk);
                if (c == 1) begin b_start = 1'b0; b_tx = 8'($urandom); end
                if (b_done === 1'b1) begin
                    nd++;
                    if (dc < 0) begin dc = c; rxd = b_rx; end
                end
            end
            checks++; if (rxd !== tot) begin errors++; $display("FAIL slave_rx[%0d] got %h want %h", i, rxd, tot); end
            checks++; if (s_gpio !== tx) begin errors++; $display("FAIL slave_gpio[%0d] got %h want %h", i, s_gpio, tx); end
            checks++; if (dc != 17 * NB + 1) begin errors++; $display("FAIL slave_done_cycle[%0d] got %0d want %0d", i, dc, 17 * NB + 1); end
            checks++; if (b_rises - r0 != 8) begin errors++; $display("FAIL slave_sclk_rises[%0d] got %0d want 8", i, b_rises - r0); end
            checks++; if (nd != 1) begin errors++; $display("FAIL slave_done_count[%0d] got %0d want 1", i, nd); end
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] tx;
        tx = 8'($urandom);
        miso_mode = 0;
        run_a(tx, ~tx, 10, 2 * PA + 5);
        checks++; if (r_ndone != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", r_ndone); end
        checks++; if (r_rises != 8) begin errors++; $display("FAIL busy_start_rises got %0d want 8", r_rises); end
        checks++; if (r_rx !== tx) begin errors++; $display("FAIL busy_start_rx got %h want %h", r_rx, tx); end
        checks++; if (a_rx !== tx) begin errors++; $display("FAIL rx_hold got %h want %h", a_rx, tx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx;
        int runs[$];
        int run, nd, last_done;
        logic seen_low;
        tx = 8'($urandom) | 8'h01;
        miso_mode = 0;
        run = 0; nd = 0; last_done = -1; seen_low = 1'b0;
        @(negedge clk);
        a_tx = tx; a_start = 1'b1;
        for (int c = 1; c <= 3 * PA + 5; c++) begin
            @(negedge clk);
            if (c == 2 * PA + 1) a_start = 1'b0;
            if (a_done === 1'b1) begin
                nd++; last_done = c;
                checks++; if (a_rx !== tx) begin errors++; $display("FAIL b2b_rx[%0d] got %h want %h", nd, a_rx, tx); end
            end
            if (a_cs_b === 1'b0) begin
                if (seen_low && run > 0) runs.push_back(run);
                run = 0; seen_low = 1'b1;
            end else if (seen_low) begin
                run++;
            end
        end
        checks++; if (nd != 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", nd); end
        checks++; if (last_done != 2 * PA + 17 * NA + 1) begin errors++; $display("FAIL b2b_third_done got %0d want %0d", last_done, 2 * PA + 17 * NA + 1); end
        checks++; if (runs.size() != 2) begin errors++; $display("FAIL b2b_gap_count got %0d want 2", runs.size()); end
        foreach (runs[j]) begin
            checks++; if (runs[j] != GA + 1) begin errors++; $display("FAIL b2b_gap_len[%0d] got %0d want %0d", j, runs[j], GA + 1); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] tx;
        int nd;
        tx = 8'($urandom) | 8'h80;
        miso_mode = 0;
        @(negedge clk);
        a_tx = tx; a_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) a_start = 1'b0;
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if ({a_cs_b, a_sclk, a_busy, a_done} !== 4'b1000) begin
            errors++; $display("FAIL midreset_ctrl got %b want 1000", {a_cs_b, a_sclk, a_busy, a_done});
        end
        checks++; if (a_rx !== 8'h00) begin errors++; $display("FAIL midreset_rx got %h want 00", a_rx); end
        nd = 0;
        repeat (3) begin @(negedge clk); if (a_done === 1'b1) nd++; end
        rst_b = 1'b1;
        repeat (PA) begin @(negedge clk); if (a_done === 1'b1) nd++; end
        checks++; if (nd != 0) begin errors++; $display("FAIL midreset_done got %0d want 0", nd); end
        checks++; if (a_rx !== 8'h00) begin errors++; $display("FAIL midreset_rx_after got %h want 00", a_rx); end
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        tx = 8'($urandom);
        run_a(tx, ~tx, -1, PA);
        checks++; if (r_done != 17 * NA + 1) begin errors++; $display("FAIL first_start_done got %0d want %0d", r_done, 17 * NA + 1); end
        checks++; if (r_rx !== tx) begin errors++; $display("FAIL first_start_rx got %h want %h", r_rx, tx); end
    endtask

    task automatic test_miso_glitch();
        for (int i = 0; i < 3; i++) begin
            pat_byte  = (i == 0) ? 8'h5A : 8'($urandom);
            pat_base  = a_rises;
            miso_mode = 1;
            run_a(8'($urandom), 8'($urandom), -1, PA);
            checks++; if (r_rx !== pat_byte) begin errors++; $display("FAIL glitch_rx[%0d] got %h want %h", i, r_rx, pat_byte); end
        end
        miso_mode = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback();
        test_slave();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_miso_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/afe_spi_master.md
AFE_SPI_MASTER -- requirements
Module: afe_spi_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: SCLK half-period in CLK cycles, legal range 2..255.
REQ-002 The block SHALL have parameter CS_GAP, default 4: minimum CLK cycles CS_B stays high between transfers, legal range 1..255.
REQ-003 The block SHALL have port CLK, input, 1 bit: single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port RST_B, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port START, input, 1 bit: transfer request, sampled only in IDLE.
REQ-006 The block SHALL have port TX_DATA, input, 8 bits: byte to shift out; becomes the slave GPIO value.
REQ-007 The block SHALL have port BUSY, output, 1 bit: high from the cycle after START is accepted until the return to IDLE.
REQ-008 The block SHALL have port DONE, output, 1 bit: one-cycle pulse when RX_DATA is updated.
REQ-009 The block SHALL have port RX_DATA, output, 8 bits: last byte received (slave TOT count).
REQ-010 The block SHALL have port SCLK, output, 1 bit: SPI clock, idle low.
REQ-011 The block SHALL have port MOSI, output, 1 bit: serial data out, MSB first.
REQ-012 The block SHALL have port MISO, input, 1 bit: serial data in, MSB first.
REQ-013 The block SHALL have port CS_B, output, 1 bit: active-low chip select, idle high.

Function
REQ-014 The block SHALL implement the states IDLE, SETUP, SCLK_LO, SCLK_HI, HOLD and GAP.
REQ-015 Let N=CLK_DIV and cycle 0 be the cycle in which START=1 is sampled in IDLE; in that cycle the block SHALL latch TX_DATA and enter SETUP.
REQ-016 In cycles 1..N (SETUP) the block SHALL drive CS_B=0, SCLK=0, MOSI=TX_DATA[7] and BUSY=1.
REQ-017 For bit k=0..7, SCLK SHALL be high in cycles (2k+1)N+1..(2k+2)N.
REQ-018 Between those high phases SCLK SHALL be low for N cycles (SCLK_LO).
REQ-019 MOSI SHALL change only on the first cycle of a low phase, taking the value TX_DATA[6-k] after bit k; data is therefore stable at each SCLK rising edge (mode 0).
REQ-020 MISO SHALL be shifted into the receive register, MSB first, on the CLK edge that drives SCLK high.
REQ-021 MISO SHALL NOT be sampled at any other time.
REQ-022 After the 8th high phase the block SHALL enter HOLD with SCLK=0 and CS_B=0 during cycles 16N+1..17N.
REQ-023 In cycle 17N+1 the block SHALL drive CS_B=1, pulse DONE=1 and present the received byte on RX_DATA, then enter GAP.
REQ-024 In GAP, BUSY SHALL remain 1 through cycle 17N+CS_GAP.
REQ-025 In cycle 17N+CS_GAP+1 the block SHALL return to IDLE and drive BUSY=0.
REQ-026 START asserted while BUSY=1 SHALL be ignored, with no queuing.
REQ-027 START held high continuously SHALL start a new transfer on the first IDLE cycle, so CS_B stays high for exactly CS_GAP+1 cycles.
REQ-028 RX_DATA SHALL hold its value between DONE pulses.
REQ-029 TX_DATA changes after cycle 0 SHALL NOT affect the transfer in progress.
REQ-030 The block SHALL generate exactly 8 SCLK rising edges per transfer, with no edge while CS_B=1.
REQ-031 The divider counter SHALL be 8 bits wide and reload to N-1 on every phase change, with no wrap-around beyond one phase.
REQ-032 The bit counter SHALL be 3 bits wide; its terminal condition SHALL be bit 7 completing its high phase.

Reset
REQ-033 While RST_B=0 the block SHALL asynchronously force state=IDLE, CS_B=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0x00 and clear all counters and shift registers.
REQ-034 A reset mid-transfer SHALL abort the transfer immediately, with no DONE and no RX_DATA update, leaving CS_B high so the slave latches a partial byte (accepted behaviour).
REQ-035 The first START after reset release SHALL be honoured with no extra delay.

Structure
REQ-036 State encodings and the default values of CLK_DIV and CS_GAP SHALL reside in shared package afe_pkg.
REQ-037 SCLK phase timing SHALL be implemented in one sub-module, afe_spi_tick: an 8-bit reloadable down-counter producing a one-cycle phase-end strobe.
REQ-038 The FSM, shift registers and outputs SHALL reside in afe_spi_master.

Verification
REQ-039 Loopback (MOSI tied to MISO), N=4, TX_DATA=0xA5 -> RX_DATA=0xA5, DONE in cycle 69, BUSY low in cycle 73.
REQ-040 Slave model with TOT=0x3C, TX_DATA=0x81, N=2 -> RX_DATA=0x3C, slave GPIO=0x81 after CS_B rises, DONE in cycle 35, exactly 8 SCLK rising edges.
REQ-041 START pulsed at cycle 10 of an active transfer -> exactly one transfer and one DONE pulse.
REQ-042 START held high for three transfers -> CS_B high for exactly CS_GAP+1 cycles between transfers, three DONE pulses.
REQ-043 RST_B low at cycle 20 -> same cycle CS_B=1, SCLK=0, BUSY=0; no DONE; RX_DATA=0x00.
REQ-044 MISO toggled during SCLK-high phases with a stable value 0x5A during low phases -> RX_DATA=0x5A.
